// File: rtl/pq_pkg.sv
// Shared types and sizing for the sorted-array priority queue.
// Key width and tag width are fixed here; the top may use fewer slots than QUEUE_DEPTH.
package pq_pkg;

  localparam int unsigned QUEUE_DEPTH = 8;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam bit          MAX_FIRST   = 1'b0;
  localparam int unsigned CNT_WIDTH   = $clog2(QUEUE_DEPTH);
  localparam int unsigned ID_WIDTH    = CNT_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } cell_t;

  // Strict comparison: equal keys never outrank each other.
  function automatic logic cell_outranks(input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b,
                                         input bit                    max_first);
    return max_first ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/pq_slot.sv
// One slot of the systolic sorted array: local comparator plus next-state select.
// Purely combinational; the storage flops live in the top level.
module pq_slot import pq_pkg::*; #(
  parameter bit MaxFirst = 1'b0,
  parameter bit IsHead   = 1'b0
) (
  input  cell_t cell_i,
  input  logic  valid_i,
  input  cell_t prev_cell_i,
  input  logic  prev_valid_i,
  input  logic  prev_outranks_i,
  input  cell_t next_cell_i,
  input  logic  next_valid_i,
  input  logic  next_outranks_i,
  input  cell_t new_cell_i,
  input  logic  push_fire_i,
  input  logic  pop_fire_i,
  output cell_t cell_d_o,
  output logic  valid_d_o,
  output logic  outranks_o
);

  logic rep_prev_outranks;

  assign outranks_o = !valid_i | cell_outranks(new_cell_i.data, cell_i.data, MaxFirst);

  // After a pop, the remaining array is shifted by one, so this slot's own comparator
  // plays the role of the "previous" slot for insertion; the head has no predecessor.
  assign rep_prev_outranks = IsHead ? 1'b0 : outranks_o;

  always_comb begin
    cell_d_o  = cell_i;
    valid_d_o = valid_i;
    unique case ({push_fire_i, pop_fire_i})
      2'b10: begin
        if (outranks_o) begin
          if (prev_outranks_i) begin
            cell_d_o  = prev_cell_i;
            valid_d_o = prev_valid_i;
          end else begin
            cell_d_o  = new_cell_i;
            valid_d_o = 1'b1;
          end
        end
      end
      2'b01: begin
        // Keep stale data when nothing valid moves in so an emptied head holds its value.
        if (next_valid_i) begin
          cell_d_o = next_cell_i;
        end
        valid_d_o = next_valid_i;
      end
      2'b11: begin
        if (!next_outranks_i) begin
          cell_d_o  = next_cell_i;
          valid_d_o = next_valid_i;
        end else if (!rep_prev_outranks) begin
          cell_d_o  = new_cell_i;
          valid_d_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pq_sorted_array.sv
// Register-based priority queue kept fully sorted; slot 0 is always the head.
// Supports push, pop, same-cycle replace and flush with valid/ready handshakes.
module pq_sorted_array import pq_pkg::*; #(
  parameter int unsigned QUEUE_DEPTH = pq_pkg::QUEUE_DEPTH,
  parameter bit          MAX_FIRST   = pq_pkg::MAX_FIRST,
  localparam int unsigned CntW       = $clog2(QUEUE_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  cell_t         push_cell_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output cell_t         pop_cell_o,
  output logic [CntW:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam logic [CntW:0] FullCount = (CntW + 1)'(QUEUE_DEPTH);

  cell_t [QUEUE_DEPTH-1:0] slot_q, slot_d, slot_nx;
  logic  [QUEUE_DEPTH-1:0] valid_q, valid_d, valid_nx, outranks;
  logic  [CntW:0]          count_q, count_d;
  logic                    push_fire, pop_fire;

  assign full_o       = (count_q == FullCount);
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign pop_valid_o  = valid_q[0];
  assign pop_cell_o   = slot_q[0];
  assign push_ready_o = !flush_i & (!full_o | pop_ready_i);
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = valid_q[0] & pop_ready_i & !flush_i;

  for (genvar i = 0; i < QUEUE_DEPTH; i++) begin : g_slot
    cell_t prev_cell, next_cell;
    logic  prev_valid, prev_or, next_valid, next_or;

    if (i == 0) begin : g_first
      assign prev_cell  = '0;
      assign prev_valid = 1'b0;
      assign prev_or    = 1'b0;
    end else begin : g_prev
      assign prev_cell  = slot_q[i-1];
      assign prev_valid = valid_q[i-1];
      assign prev_or    = outranks[i-1];
    end

    // Beyond the last slot behaves like an always-free position.
    if (i == QUEUE_DEPTH - 1) begin : g_last
      assign next_cell  = '0;
      assign next_valid = 1'b0;
      assign next_or    = 1'b1;
    end else begin : g_next
      assign next_cell  = slot_q[i+1];
      assign next_valid = valid_q[i+1];
      assign next_or    = outranks[i+1];
    end

    pq_slot #(
      .MaxFirst (MAX_FIRST),
      .IsHead   (i == 0)
    ) u_slot (
      .cell_i          (slot_q[i]),
      .valid_i         (valid_q[i]),
      .prev_cell_i     (prev_cell),
      .prev_valid_i    (prev_valid),
      .prev_outranks_i (prev_or),
      .next_cell_i     (next_cell),
      .next_valid_i    (next_valid),
      .next_outranks_i (next_or),
      .new_cell_i      (push_cell_i),
      .push_fire_i     (push_fire),
      .pop_fire_i      (pop_fire),
      .cell_d_o        (slot_nx[i]),
      .valid_d_o       (valid_nx[i]),
      .outranks_o      (outranks[i])
    );
  end

  always_comb begin
    slot_d  = slot_nx;
    valid_d = valid_nx;
    count_d = count_q + (CntW + 1)'(push_fire) - (CntW + 1)'(pop_fire);
    if (flush_i) begin
      slot_d  = '0;
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pq_sorted_array.sv
// Self-checking bench: scenario tasks plus a scoreboard of expected pop order.
module tb_pq_sorted_array;
  import pq_pkg::*;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush, push_valid, pop_ready, push_ready, pop_valid, empty, full;
  cell_t      push_cell, pop_cell;
  logic [2:0] count;

  logic       flush_m, push_valid_m, pop_ready_m, push_ready_m, pop_valid_m, empty_m, full_m;
  cell_t      push_cell_m, pop_cell_m;
  logic [2:0] count_m;

  int n_cmp = 0;
  int n_bad = 0;
  cell_t sb[$];
  cell_t exp_c;

  pq_sorted_array #(.QUEUE_DEPTH(Depth), .MAX_FIRST(1'b0)) dut_min (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_cell_i(push_cell),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready), .pop_cell_o(pop_cell),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  pq_sorted_array #(.QUEUE_DEPTH(Depth), .MAX_FIRST(1'b1)) dut_max (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_m),
    .push_valid_i(push_valid_m), .push_ready_o(push_ready_m), .push_cell_i(push_cell_m),
    .pop_valid_o(pop_valid_m), .pop_ready_i(pop_ready_m), .pop_cell_o(pop_cell_m),
    .count_o(count_m), .empty_o(empty_m), .full_o(full_m)
  );

  function automatic cell_t mk(input int d, input int id);
    cell_t c;
    c.data = d[DATA_WIDTH-1:0];
    c.id   = id[ID_WIDTH-1:0];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; push_valid = 0; pop_ready = 0; push_cell = '0;
    flush_m = 0; push_valid_m = 0; pop_ready_m = 0; push_cell_m = '0;
  endtask

  task automatic push(input int d, input int id);
    push_valid = 1; push_cell = mk(d, id);
    tick();
    push_valid = 0;
  endtask

  task automatic push_m(input int d, input int id);
    push_valid_m = 1; push_cell_m = mk(d, id);
    tick();
    push_valid_m = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    tick(); tick();
    rst = 0; #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
    n_cmp++; if (pop_cell !== cell_t'(0)) begin n_bad++; $display("FAIL reset_pop_cell got %h want 0", pop_cell); end
    n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
    n_cmp++; if (count_m !== 3'd0) begin n_bad++; $display("FAIL reset_count_max got %0d want 0", count_m); end
  endtask

  task automatic test_sorting();
    push(5, 1); push(2, 2); push(9, 3); push(2, 4);
    sb.push_back(mk(2, 2)); sb.push_back(mk(2, 4)); sb.push_back(mk(5, 1)); sb.push_back(mk(9, 3));
    pop_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (count !== 3'(4 - k)) begin n_bad++; $display("FAIL sort_count got %0d want %0d", count, 4 - k); end
      n_cmp++; if (pop_valid !== 1'b1) begin n_bad++; $display("FAIL sort_pop_valid got %b want 1", pop_valid); end
      exp_c = sb.pop_front();
      n_cmp++; if (pop_cell !== exp_c) begin n_bad++; $display("FAIL sort_order[%0d] got %h want %h", k, pop_cell, exp_c); end
      tick();
    end
    pop_ready = 0; #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL sort_end_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL sort_end_empty got %b want 1", empty); end
  endtask

  task automatic test_full();
    push(1, 1); push(3, 2); push(5, 3); push(7, 4);
    #1;
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag got %b want 1", full); end
    push_valid = 1; push_cell = mk(0, 5); pop_ready = 0; #1;
    n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL full_push_ready got %b want 0", push_ready); end
    tick();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_hold_count got %0d want 4", count); end
    n_cmp++; if (pop_cell !== mk(1, 1)) begin n_bad++; $display("FAIL full_hold_head got %h want %h", pop_cell, mk(1, 1)); end
    pop_ready = 1; #1;
    n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL full_replace_ready got %b want 1", push_ready); end
    n_cmp++; if (pop_cell !== mk(1, 1)) begin n_bad++; $display("FAIL full_replace_pop got %h want %h", pop_cell, mk(1, 1)); end
    tick();
    push_valid = 0; pop_ready = 0; #1;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_replace_count got %0d want 4", count); end
    sb.push_back(mk(0, 5)); sb.push_back(mk(3, 2)); sb.push_back(mk(5, 3)); sb.push_back(mk(7, 4));
    pop_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_c = sb.pop_front();
      n_cmp++; if (pop_cell !== exp_c) begin n_bad++; $display("FAIL full_drain[%0d] got %h want %h", k, pop_cell, exp_c); end
      tick();
    end
    pop_ready = 0; #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL full_drain_count got %0d want 0", count); end
  endtask

  task automatic test_replace();
    push(4, 1); push(6, 2);
    sb.push_back(mk(4, 1)); sb.push_back(mk(6, 2)); sb.push_back(mk(8, 3));
    push_valid = 1; push_cell = mk(8, 3); pop_ready = 1; #1;
    exp_c = sb.pop_front();
    n_cmp++; if (pop_cell !== exp_c) begin n_bad++; $display("FAIL replace_pop got %h want %h", pop_cell, exp_c); end
    tick();
    push_valid = 0; pop_ready = 0; #1;
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL replace_count got %0d want 2", count); end
    pop_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp_c = sb.pop_front();
      n_cmp++; if (pop_cell !== exp_c) begin n_bad++; $display("FAIL replace_rest[%0d] got %h want %h", k, pop_cell, exp_c); end
      tick();
    end
    pop_ready = 0;
  endtask

  task automatic test_flush();
    push(1, 1); push(2, 2); push(3, 3);
    flush = 1; push_valid = 1; push_cell = mk(0, 7); pop_ready = 1; #1;
    n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL flush_push_ready got %b want 0", push_ready); end
    tick();
    idle(); #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL flush_pop_valid got %b want 0", pop_valid); end
    n_cmp++; if (pop_cell !== cell_t'(0)) begin n_bad++; $display("FAIL flush_pop_cell got %h want 0", pop_cell); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty got %b want 1", empty); end
  endtask

  task automatic test_max();
    push_m(5, 1); push_m(2, 2); push_m(9, 3);
    sb.push_back(mk(9, 3)); sb.push_back(mk(5, 1)); sb.push_back(mk(2, 2));
    pop_ready_m = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_c = sb.pop_front();
      n_cmp++; if (pop_cell_m !== exp_c) begin n_bad++; $display("FAIL max_order[%0d] got %h want %h", k, pop_cell_m, exp_c); end
      tick();
    end
    pop_ready_m = 0; #1;
    n_cmp++; if (empty_m !== 1'b1) begin n_bad++; $display("FAIL max_empty got %b want 1", empty_m); end
  endtask

  // Random push/pop traffic against a reference queue that inserts after equal keys.
  task automatic test_back_to_back();
    cell_t mq[$];
    int    next_id = 0;
    logic  exp_ready, pf, popf;
    int    idx;
    for (int cyc = 0; cyc < 300; cyc++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      pop_ready  = ($urandom_range(0, 3) != 0);
      push_cell  = mk($urandom_range(0, 7), next_id);
      #1;
      exp_ready = (mq.size() != Depth) || pop_ready;
      n_cmp++; if (push_ready !== exp_ready) begin n_bad++; $display("FAIL b2b_push_ready cyc %0d got %b want %b", cyc, push_ready, exp_ready); end
      n_cmp++; if (pop_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL b2b_pop_valid cyc %0d got %b want %b", cyc, pop_valid, mq.size() != 0); end
      n_cmp++; if (count !== 3'(mq.size())) begin n_bad++; $display("FAIL b2b_count cyc %0d got %0d want %0d", cyc, count, mq.size()); end
      pf   = push_valid && exp_ready;
      popf = pop_ready && (mq.size() != 0);
      if (popf) begin
        exp_c = mq.pop_front();
        n_cmp++; if (pop_cell !== exp_c) begin n_bad++; $display("FAIL b2b_pop cyc %0d got %h want %h", cyc, pop_cell, exp_c); end
      end
      if (pf) begin
        idx = mq.size();
        for (int j = mq.size() - 1; j >= 0; j--) begin
          if (push_cell.data < mq[j].data) idx = j;
        end
        mq.insert(idx, push_cell);
        next_id = (next_id + 1) % 16;
      end
      tick();
    end
    push_valid = 0; pop_ready = 1;
    for (int k = 0; k < Depth && mq.size() != 0; k++) begin
      #1;
      exp_c = mq.pop_front();
      n_cmp++; if (pop_cell !== exp_c) begin n_bad++; $display("FAIL b2b_drain[%0d] got %h want %h", k, pop_cell, exp_c); end
      tick();
    end
    pop_ready = 0; #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL b2b_end_count got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    push(6, 1); push(2, 2);
    push_valid = 1; pop_ready = 1;
    for (int k = 0; k < 3; k++) begin
      push_cell = mk(k + 4, k + 3);
      tick();
    end
    rst = 1; push_cell = mk(1, 9);
    tick();
    rst = 0; idle(); #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", count); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_pop_valid got %b want 0", pop_valid); end
    n_cmp++; if (pop_cell !== cell_t'(0)) begin n_bad++; $display("FAIL rstmid_pop_cell got %h want 0", pop_cell); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty got %b want 1", empty); end
    n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_push_ready got %b want 1", push_ready); end
    push(3, 1);
    pop_ready = 1; #1;
    n_cmp++; if (pop_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_after_valid got %b want 1", pop_valid); end
    n_cmp++; if (pop_cell !== mk(3, 1)) begin n_bad++; $display("FAIL rstmid_after_cell got %h want %h", pop_cell, mk(3, 1)); end
    tick();
    pop_ready = 0; #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rstmid_after_count got %0d want 0", count); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_sorting();
    test_full();
    test_replace();
    test_flush();
    test_max();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
